// File: rtl/conv_encoder_213.sv
// Framed (2,1,3) convolutional encoder: one information bit per handshake,
// M zero tail bits per frame, registered symbol output with frame markers.
module conv_encoder_213 #(
    parameter int         FRAME_LEN = 16,
    parameter int         M         = 3,
    parameter logic [3:0] G0        = 4'b1111,
    parameter logic [3:0] G1        = 4'b1101
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] rx,
    output logic       rx_valid,
    output logic       seq_ready,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t     state, state_nx;
    logic [2:0] s, s_nx;
    logic [7:0] cnt, cnt_nx;
    logic       accept;
    logic       gen;
    logic       e;
    logic       first;
    logic       last_tail;
    logic [3:0] t;

    assign accept = din_valid && din_ready;
    assign t      = {e, s[0], s[1], s[2]};

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_nx  = state;
        s_nx      = s;
        cnt_nx    = cnt;
        gen       = 1'b0;
        e         = 1'b0;
        first     = 1'b0;
        last_tail = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    gen   = 1'b1;
                    e     = din;
                    first = 1'b1;
                    if (FRAME_LEN == 1) begin
                        state_nx = TAIL;
                        cnt_nx   = 8'd0;
                    end else begin
                        state_nx = DATA;
                        cnt_nx   = 8'd1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    gen = 1'b1;
                    e   = din;
                    if (cnt == 8'(FRAME_LEN - 1)) begin
                        state_nx = TAIL;
                        cnt_nx   = 8'd0;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            TAIL: begin
                gen = 1'b1;
                if (cnt == 8'(M - 1)) begin
                    state_nx  = IDLE;
                    cnt_nx    = 8'd0;
                    last_tail = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // New bit enters the LSB so predecessors (j, j+4) map onto (2j, 2j+1).
        if (gen) s_nx = {s[1:0], e};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            s          <= 3'b000;
            cnt        <= 8'd0;
            din_ready  <= 1'b0;
            rx         <= 2'b00;
            rx_valid   <= 1'b0;
            seq_ready  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            s          <= s_nx;
            cnt        <= cnt_nx;
            din_ready  <= (state_nx != TAIL);
            rx_valid   <= gen;
            seq_ready  <= first;
            frame_done <= last_tail;
            // The last tail symbol is still in flight while the FSM returns to IDLE.
            busy       <= (state_nx != IDLE) || (state == TAIL);
            if (gen) rx <= {^(t & G0), ^(t & G1)};
        end
    end

endmodule

// File: tb/tb_conv_encoder_213.sv
// Randomized self-checking bench for conv_encoder_213: a FRAME_LEN=4 and a
// FRAME_LEN=16 instance are compared against a convolution-sum reference model.
module tb_conv_encoder_213;

    localparam logic [3:0] G0 = 4'b1111;
    localparam logic [3:0] G1 = 4'b1101;
    localparam int         M  = 3;

    typedef struct {
        logic [1:0] rx;
        logic       sof;
        logic       eof;
        int         cyc;
    } sym_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] din, din_valid, din_ready, rx_valid, seq_ready, frame_done, busy;
    logic [1:0] rx0, rx1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   low_cnt  = 0;
    sym_t q0[$], q1[$], exp_q[$];
    bit   vec[$];

    always #5 clock = ~clock;

    conv_encoder_213 #(.FRAME_LEN(4)) dut4 (
        .clock(clock), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .rx(rx0), .rx_valid(rx_valid[0]),
        .seq_ready(seq_ready[0]), .frame_done(frame_done[0]), .busy(busy[0])
    );

    conv_encoder_213 #(.FRAME_LEN(16)) dut16 (
        .clock(clock), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .rx(rx1), .rx_valid(rx_valid[1]),
        .seq_ready(seq_ready[1]), .frame_done(frame_done[1]), .busy(busy[1])
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        sym_t r;
        if (reset === 1'b1 && din_ready[0] === 1'b0) low_cnt <= low_cnt + 1;
        if (rx_valid[0]) begin
            r.rx = rx0; r.sof = seq_ready[0]; r.eof = frame_done[0]; r.cyc = cyc;
            q0.push_back(r);
        end
        if (rx_valid[1]) begin
            r.rx = rx1; r.sof = seq_ready[1]; r.eof = frame_done[1]; r.cyc = cyc;
            q1.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each frame is the data bits followed by M zeros; every symbol
    // is the GF(2) convolution of that sequence with the generator taps.
    task automatic build_exp(input int frame_len, input bit bits[$]);
        exp_q.delete();
        for (int f = 0; f < bits.size() / frame_len; f++) begin
            bit u[$];
            for (int k = 0; k < frame_len; k++) u.push_back(bits[f * frame_len + k]);
            for (int k = 0; k < M; k++) u.push_back(1'b0);
            for (int k = 0; k < frame_len + M; k++) begin
                sym_t r;
                bit   c1 = 1'b0, c0 = 1'b0;
                for (int j = 0; j <= M; j++) begin
                    if (k - j >= 0) begin
                        c1 ^= G0[3 - j] & u[k - j];
                        c0 ^= G1[3 - j] & u[k - j];
                    end
                end
                r.rx = {c1, c0}; r.sof = (k == 0); r.eof = (k == frame_len + M - 1); r.cyc = 0;
                exp_q.push_back(r);
            end
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic fill(input logic [31:0] pattern, input int n);
        vec.delete();
        for (int i = n - 1; i >= 0; i--) vec.push_back(pattern[i]);
    endtask

    task automatic fill_random(input int n);
        vec.delete();
        for (int i = 0; i < n; i++) vec.push_back(bit'($urandom_range(1)));
    endtask

    // Called at #1 after a rising edge; returns at #1 after the last accepting edge.
    task automatic send(input int sel, input bit bits[$], input int stall_pct, input bit hold);
        for (int i = 0; i < bits.size(); i++) begin
            int n = 0;
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                din_valid[sel] = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
            end
            din[sel]       = bits[i];
            din_valid[sel] = 1'b1;
            while (din_ready[sel] !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
            if (n >= 50) check("ready_timeout", din_ready[sel], 1);
            @(posedge clock); #1;
        end
        if (!hold) din_valid[sel] = 1'b0;
    endtask

    task automatic wait_syms(input int sel, input int n);
        int k = 0;
        while (qsize(sel) < n && k < 300) begin @(posedge clock); #1; k++; end
        if (k >= 300) check("sym_timeout", qsize(sel), n);
    endtask

    task automatic compare(input int sel, input string tag);
        sym_t got[$];
        got = (sel == 0) ? q0 : q1;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_rx[%0d]", tag, i), got[i].rx, exp_q[i].rx);
            check($sformatf("%s_sof[%0d]", tag, i), got[i].sof, exp_q[i].sof);
            check($sformatf("%s_eof[%0d]", tag, i), got[i].eof, exp_q[i].eof);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] kv [7];
        int         eofs;
        int         low_base;
        kv = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};

        reset = 1'b0; din = '0; din_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outs4", {rx0, rx_valid[0], seq_ready[0], frame_done[0], busy[0], din_ready[0]}, 0);
        check("reset_outs16", {rx1, rx_valid[1], seq_ready[1], frame_done[1], busy[1], din_ready[1]}, 0);
        reset = 1'b1;
        check("ready_before_edge", din_ready[0], 0);
        @(posedge clock); #1;
        check("ready_after_release", din_ready[0], 1);

        // Known vector 1,0,1,1 continuous
        q0.delete();
        fill(32'b1011, 4);
        send(0, vec, 0, 0);
        check("busy_in_frame", busy[0], 1);
        wait_syms(0, 7);
        check("busy_after_frame", busy[0], 0);
        build_exp(4, vec);
        compare(0, "known");
        for (int i = 0; i < 7 && i < q0.size(); i++) check($sformatf("known_const[%0d]", i), q0[i].rx, kv[i]);
        if (q0.size() == 7) check("known_contiguous", q0[6].cyc - q0[0].cyc, 6);

        // Same vector with a 3-cycle stall between bits 2 and 3
        q0.delete();
        fill(32'b10, 2);
        send(0, vec, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check($sformatf("stall_hold_rx[%0d]", i), rx0, 2'b11);
            check($sformatf("stall_valid[%0d]", i), rx_valid[0], 0);
        end
        fill(32'b11, 2);
        send(0, vec, 0, 0);
        wait_syms(0, 7);
        fill(32'b1011, 4);
        build_exp(4, vec);
        compare(0, "stall");
        if (q0.size() == 7) check("stall_gap", q0[2].cyc - q0[1].cyc, 4);

        // Back-to-back frames with din_valid held high
        q0.delete();
        low_base = low_cnt;
        fill(32'b1011_1011, 8);
        send(0, vec, 0, 1);
        din_valid[0] = 1'b0;
        wait_syms(0, 14);
        build_exp(4, vec);
        compare(0, "b2b");
        if (q0.size() == 14) check("b2b_sof_after_eof", q0[7].cyc - q0[6].cyc, 1);
        check("b2b_ready_low", low_cnt - low_base, 2 * M);

        // All-zero frame on the FRAME_LEN=16 instance
        q1.delete();
        fill(32'h0, 16);
        send(1, vec, 0, 0);
        wait_syms(1, 19);
        build_exp(16, vec);
        compare(1, "zero16");

        // Reset in the middle of a frame
        q0.delete();
        fill(32'b11, 2);
        send(0, vec, 0, 0);
        reset = 1'b0;
        #1;
        check("midrst_outs", {rx0, rx_valid[0], seq_ready[0], frame_done[0], busy[0], din_ready[0]}, 0);
        repeat (2) begin @(posedge clock); #1; end
        eofs = 0;
        foreach (q0[i]) eofs += int'(q0[i].eof);
        check("midrst_no_done", eofs, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_ready", din_ready[0], 1);
        q0.delete();
        fill(32'b1011, 4);
        send(0, vec, 0, 0);
        wait_syms(0, 7);
        build_exp(4, vec);
        compare(0, "after_rst");

        // Random frames with random stalls
        for (int f = 0; f < 6; f++) begin
            q0.delete();
            fill_random(4);
            send(0, vec, 25, 0);
            wait_syms(0, 7);
            build_exp(4, vec);
            compare(0, $sformatf("rand4_%0d", f));
        end
        q1.delete();
        fill_random(48);
        send(1, vec, 20, 0);
        wait_syms(1, 57);
        build_exp(16, vec);
        compare(1, "rand16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_encoder_213.md
Name: conv_encoder_213

Overview:
Framed (2,1,3) convolutional encoder that generates the 2-bit symbol stream for the 8-state Viterbi decoder. It accepts one information bit per handshake. After each frame it appends M zero tail bits so the trellis terminates in state 0. It marks the first symbol of each frame with a seq_ready pulse and the last symbol with frame_done.

Parameters:
FRAME_LEN, 16, information bits per frame (legal range 1..255)
M, 3, encoder memory (tail length); fixed at 3 for the 8-state trellis
G0, 4'b1111, generator for rx[1]; taps over {din, s[0], s[1], s[2]}, MSB = din
G1, 4'b1101, generator for rx[0]; same tap ordering

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
din  input  1  information bit
din_valid  input  1  din is valid this cycle
din_ready  output  1  encoder accepts din this cycle
rx  output  2  encoded symbol {c1,c0}; feeds the decoder Rx input
rx_valid  output  1  rx holds a new symbol this cycle
seq_ready  output  1  one-cycle pulse coincident with the first symbol of a frame
frame_done  output  1  one-cycle pulse coincident with the last tail symbol
busy  output  1  high from the first accepted bit until the last tail symbol is emitted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register s[2:0]=0; counter=0.
  - rx=2'b00; rx_valid=0; seq_ready=0; frame_done=0; busy=0; din_ready=0.
  - din_ready goes high in the first cycle after reset deassertion.
- Encoding function, with tap vector t = {e, s[0], s[1], s[2]}, where e = din in DATA and e = 0 in TAIL:
  - c1 = ^(t & G0); c0 = ^(t & G1).
  - Next state: s <= {s[1:0], e}, i.e. new bit enters the LSB. This matches the decoder's predecessor pairs (j, j+4) -> (2j, 2j+1).
- FSM states: IDLE, DATA, TAIL.
  - IDLE: din_ready=1, busy=0. When din_valid=1, accept bit 0 of the frame, emit its symbol and go to DATA; the counter counts accepted bits. If FRAME_LEN=1, go directly to TAIL.
  - DATA: din_ready=1. Each cycle with din_valid=1 accepts one bit. When the FRAME_LEN-th bit is accepted, go to TAIL and reset the counter to 0. A cycle with din_valid=0 produces no symbol, and s and the counter hold.
  - TAIL: din_ready=0, and din is ignored. Emit exactly M symbols on consecutive cycles with e=0. On the M-th symbol go to IDLE; s is then 000 by construction.
- Output timing:
  - All outputs are registered. A symbol appears on rx with rx_valid=1 in the cycle after its bit is accepted (latency 1), or after the TAIL cycle that generates it.
  - rx holds its last value while rx_valid=0.
  - seq_ready=1 only together with the frame's first rx_valid. frame_done=1 only together with the M-th tail symbol.
- Boundary conditions:
  - Back-to-back frames: the cycle the last tail symbol is generated, the FSM is in IDLE next, so din_ready=1 in that cycle. Minimum gap between the last data symbol of frame n and the first symbol of frame n+1 is M+1 cycles (M tail symbols plus one cycle to accept the new bit).
  - A frame whose data stalls (din_valid=0) waits indefinitely. There is no timeout.
  - Reset mid-frame: the frame is abandoned, s is cleared, and no frame_done is generated.
  - busy = (state != IDLE) or rx_valid of a tail symbol still pending output.
- Counter width: 8 bits. It never exceeds FRAME_LEN-1 in DATA or M-1 in TAIL.

Test Plan:
- Reset check: assert reset=0 mid-operation -> rx=00, rx_valid=0, seq_ready=0, frame_done=0, busy=0 immediately; din_ready=1 one cycle after release.
- Known vector, FRAME_LEN=4, din=1,0,1,1 continuous -> rx sequence 11,11,01,11 then tail 01,01,11. Both s and the final state return to 000. seq_ready accompanies the first 11; frame_done accompanies the last 11; exactly 7 rx_valid pulses.
- All-zero frame, FRAME_LEN=16 -> 19 symbols all 00; frame_done on the 19th symbol.
- Stall: same vector as the known-vector test with din_valid low for 3 cycles between bits 2 and 3 -> identical symbol sequence; rx_valid gaps match the stall; rx holds 11 during the gap.
- Back-to-back: two frames of 1,0,1,1 with din_valid held high -> second frame's seq_ready occurs 1 cycle after the first frame's frame_done; din_ready=0 for exactly M cycles.
- Loopback: random frames through the encoder into the 8-state decoder with no channel errors -> decoded bits equal the input bits and no sync_error.
